acionador_bomba_agua: RTL and testbench

Sequential actuator driver on the receiving end of the water-flow controller's request output S. It converts the level request into a safe valve/pump sequence: valve opens before the pump starts and closes after it stops. It enforces minimum on and off times, checks a flow sensor, and latches a fault on no-flow or over-run. It sits between the combinational flow-control logic and the physical valve and pump drivers.

---
 rtl/acionador_bomba_agua.sv | 120 ++++++++++++
 tb/tb_acionador_bomba_agua.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/acionador_bomba_agua.sv
// Valve/pump sequencer: opens the valve before starting the pump and closes it after stopping,
// with minimum on/off times, a flow check and over-run protection that latch a fault.
module acionador_bomba_agua #(
    parameter int T_PARTIDA = 4,
    parameter int T_MIN_ON  = 8,
    parameter int T_MIN_OFF = 8,
    parameter int T_MAX_ON  = 1000,
    parameter int W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       S,
    input  logic       fluxo_ok,
    input  logic       ack_falha,
    output logic       valvula,
    output logic       bomba,
    output logic       falha,
    output logic [2:0] estado
);

    localparam logic [2:0] ST_DESLIGADO    = 3'd0;
    localparam logic [2:0] ST_ABRE_VALVULA = 3'd1;
    localparam logic [2:0] ST_LIGADO       = 3'd2;
    localparam logic [2:0] ST_DESLIGANDO   = 3'd3;
    localparam logic [2:0] ST_REPOUSO      = 3'd4;
    localparam logic [2:0] ST_FALHA        = 3'd5;

    localparam logic [W-1:0] CNT_ONE       = W'(1);
    localparam logic [W-1:0] CNT_MAX       = {W{1'b1}};
    localparam logic [W-1:0] PARTIDA_LAST  = W'(T_PARTIDA - 1);
    localparam logic [W-1:0] PARTIDA_GRACE = W'(T_PARTIDA);
    localparam logic [W-1:0] MIN_ON_LAST   = W'(T_MIN_ON - 1);
    localparam logic [W-1:0] MIN_OFF_LAST  = W'(T_MIN_OFF - 1);
    localparam logic [W-1:0] MAX_ON_LAST   = W'(T_MAX_ON - 1);

    logic         s_meta_q;
    logic         s_sync_q;
    logic         fluxo_meta_q;
    logic         fluxo_sync_q;
    logic [2:0]   estado_q;
    logic [2:0]   estado_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // State register, counter and the two input synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta_q     <= 1'b0;
            s_sync_q     <= 1'b0;
            fluxo_meta_q <= 1'b0;
            fluxo_sync_q <= 1'b0;
            estado_q     <= ST_DESLIGADO;
            cnt_q        <= '0;
        end else begin
            s_meta_q     <= S;
            s_sync_q     <= s_meta_q;
            fluxo_meta_q <= fluxo_ok;
            fluxo_sync_q <= fluxo_meta_q;
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_DESLIGADO: begin
                if (s_sync_q) estado_d = ST_ABRE_VALVULA;
            end
            ST_ABRE_VALVULA: begin
                if (!s_sync_q)                  estado_d = ST_REPOUSO;
                else if (cnt_q == PARTIDA_LAST) estado_d = ST_LIGADO;
            end
            ST_LIGADO: begin
                // Fault conditions take precedence over a normal release
                if (cnt_q >= PARTIDA_GRACE && !fluxo_sync_q)   estado_d = ST_FALHA;
                else if (cnt_q == MAX_ON_LAST)                 estado_d = ST_FALHA;
                else if (!s_sync_q && cnt_q >= MIN_ON_LAST)    estado_d = ST_DESLIGANDO;
            end
            ST_DESLIGANDO: begin
                if (cnt_q == PARTIDA_LAST) estado_d = ST_REPOUSO;
            end
            ST_REPOUSO: begin
                if (cnt_q == MIN_OFF_LAST) estado_d = ST_DESLIGADO;
            end
            ST_FALHA: begin
                if (ack_falha && !s_sync_q) estado_d = ST_REPOUSO;
            end
            default: estado_d = ST_DESLIGADO;
        endcase

        // Every transition restarts the dwell counter; otherwise it counts and saturates
        if (estado_d != estado_q)  cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        else                       cnt_d = cnt_q;
    end

    always_comb begin
        valvula = 1'b0;
        bomba   = 1'b0;
        falha   = 1'b0;
        case (estado_q)
            ST_ABRE_VALVULA: valvula = 1'b1;
            ST_LIGADO: begin
                valvula = 1'b1;
                bomba   = 1'b1;
            end
            ST_DESLIGANDO:   valvula = 1'b1;
            ST_FALHA:        falha   = 1'b1;
            default: begin
                valvula = 1'b0;
                bomba   = 1'b0;
                falha   = 1'b0;
            end
        endcase
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_acionador_bomba_agua.sv
// Directed bench: expected {estado, valvula, bomba, falha} words are queued with the edge
// at which they must appear and popped/compared one sample after that edge.
module tb_acionador_bomba_agua;

    logic       clk;
    logic       rst_n;
    logic       S;
    logic       fluxo_ok;
    logic       ack_falha;
    logic       valvula;
    logic       bomba;
    logic       falha;
    logic [2:0] estado;
    logic [5:0] obs;

    localparam logic [5:0] E_DESL  = 6'b000_000;
    localparam logic [5:0] E_ABRE  = 6'b001_100;
    localparam logic [5:0] E_LIG   = 6'b010_110;
    localparam logic [5:0] E_DESLG = 6'b011_100;
    localparam logic [5:0] E_REP   = 6'b100_000;
    localparam logic [5:0] E_FAL   = 6'b101_001;

    typedef struct {
        int         edge_n;
        logic [5:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];
    int  n_asserts;
    int  n_fails;
    int  edge_cnt;
    int  bomba_cycles;

    acionador_bomba_agua #(
        .T_PARTIDA(4),
        .T_MIN_ON (8),
        .T_MIN_OFF(8),
        .T_MAX_ON (50),
        .W        (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .S        (S),
        .fluxo_ok (fluxo_ok),
        .ack_falha(ack_falha),
        .valvula  (valvula),
        .bomba    (bomba),
        .falha    (falha),
        .estado   (estado)
    );

    assign obs = {estado, valvula, bomba, falha};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int e, input logic [5:0] x, input string tag);
        sb_t item;
        item.edge_n = e;
        item.exp    = x;
        item.tag    = tag;
        sb.push_back(item);
    endtask

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] x);
        n_asserts++;
        assert (o === x) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, x);
        end
    endtask

    // One clock edge, then sample and retire every expectation due at or before this edge
    task automatic step();
        sb_t item;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (bomba) bomba_cycles++;
        while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
            item = sb.pop_front();
            n_asserts++;
            assert (obs === item.exp) else begin
                n_fails++;
                $error("FAIL %s (edge %0d): observed %b expected %b",
                       item.tag, edge_cnt, obs, item.exp);
            end
            $display("edge %0d %s obs=%b exp=%b", edge_cnt, item.tag, obs, item.exp);
        end
    endtask

    task automatic goto_edge(input int n);
        while (edge_cnt < n) step();
    endtask

    task automatic start_scenario();
        edge_cnt     = 0;
        bomba_cycles = 0;
    endtask

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        edge_cnt  = 0;
        bomba_cycles = 0;
        S         = 1'b0;
        fluxo_ok  = 1'b1;
        ack_falha = 1'b0;
        rst_n     = 1'b0;

        // Reset held for 3 cycles, then idle with S low
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_hold", {26'd0, obs}, {26'd0, E_DESL});
        rst_n = 1'b1;
        start_scenario();
        push(1, E_DESL, "idle_e1");
        push(10, E_DESL, "idle_e10");
        push(20, E_DESL, "idle_e20");
        goto_edge(20);

        // Normal cycle
        start_scenario();
        S = 1'b1;
        fluxo_ok = 1'b1;
        push(2, E_DESL, "norm_sync_wait");
        push(3, E_ABRE, "norm_valve_open");
        push(6, E_ABRE, "norm_valve_lead");
        push(7, E_LIG, "norm_pump_on");
        push(30, E_LIG, "norm_running");
        goto_edge(30);
        S = 1'b0;
        push(32, E_LIG, "norm_release_sync");
        push(33, E_DESLG, "norm_pump_off");
        push(36, E_DESLG, "norm_valve_lag");
        push(37, E_REP, "norm_valve_closed");
        push(44, E_REP, "norm_rest_end");
        push(45, E_DESL, "norm_idle");
        goto_edge(45);

        // Short pulse aborts in ABRE_VALVULA
        start_scenario();
        S = 1'b1;
        push(3, E_ABRE, "short_open");
        push(4, E_ABRE, "short_hold");
        push(5, E_REP, "short_abort");
        push(12, E_REP, "short_rest");
        push(13, E_DESL, "short_idle");
        goto_edge(2);
        S = 1'b0;
        goto_edge(13);
        check_val("short_no_pump", bomba_cycles, 0);

        // Minimum on-time
        start_scenario();
        S = 1'b1;
        push(7, E_LIG, "minon_pump_on");
        goto_edge(8);
        S = 1'b0;
        push(14, E_LIG, "minon_hold");
        push(15, E_DESLG, "minon_release");
        push(19, E_REP, "minon_rest");
        push(27, E_DESL, "minon_idle");
        goto_edge(27);
        check_val("minon_pump_cycles", bomba_cycles, 8);

        // No flow: fault, ack ignored while S high, accepted after S drops
        start_scenario();
        S = 1'b1;
        fluxo_ok = 1'b0;
        push(7, E_LIG, "noflow_pump_on");
        push(11, E_LIG, "noflow_grace");
        push(12, E_FAL, "noflow_fault");
        goto_edge(12);
        ack_falha = 1'b1;
        push(15, E_FAL, "noflow_ack_ignored");
        goto_edge(15);
        ack_falha = 1'b0;
        S = 1'b0;
        push(18, E_FAL, "noflow_fault_held");
        goto_edge(18);
        ack_falha = 1'b1;
        push(19, E_REP, "noflow_ack_taken");
        goto_edge(19);
        ack_falha = 1'b0;
        fluxo_ok = 1'b1;
        push(27, E_DESL, "noflow_idle");
        goto_edge(27);

        // Over-run
        start_scenario();
        S = 1'b1;
        push(7, E_LIG, "overrun_pump_on");
        push(56, E_LIG, "overrun_last_ok");
        push(57, E_FAL, "overrun_fault");
        goto_edge(57);
        S = 1'b0;
        ack_falha = 1'b1;
        push(59, E_FAL, "overrun_wait_sync");
        push(60, E_REP, "overrun_cleared");
        goto_edge(60);
        ack_falha = 1'b0;
        push(68, E_DESL, "overrun_idle");
        goto_edge(68);

        // Asynchronous reset in the middle of LIGADO
        start_scenario();
        S = 1'b1;
        push(7, E_LIG, "arst_pump_on");
        push(20, E_LIG, "arst_running");
        goto_edge(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_no_edge", {26'd0, obs}, {26'd0, E_DESL});
        S = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("arst_released", {26'd0, obs}, {26'd0, E_DESL});

        check_val("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
